ram_responder: RTL and testbench
================================

# ram_responder

Word-addressed RAM target that answers the memory controller's single RAM port (ramREN/ramWEN/ramaddr/ramstore) with ramload and the ramstate handshake (FREE/BUSY/ACCESS/ERROR). It sits below the arbiter, replacing the behavioural RAM in system simulation. It has a programmable access latency, so arbitration and coherence paths can be exercised under realistic wait states.

## Interface
- LAT, 2: BUSY cycles inserted before ACCESS (0..15).
- DEPTH, 16384: memory size in 32-bit words (power of two).
- ADDR_W, $clog2(DEPTH): word-index width.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- ramREN  in  1  read request, level, held until ACCESS seen.
- ramWEN  in  1  write request, level, held until ACCESS seen.
- ramaddr  in  32  byte address (word_t).
- ramstore  in  32  write data (word_t).
- ramload  out  32  read data, valid only while ramstate==ACCESS after a read.
- ramstate  out  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: FREE, BUSY, ACCESS, ERROR. ramstate is the registered state (Moore), so the controller may use it combinationally in the same cycle.
- FREE:
  - Request present (ramREN|ramWEN) → latch kind, ramaddr, ramstore.
  - Go to BUSY with counter=LAT-1, or straight to ACCESS if LAT==0.
- BUSY:
  - Counter decrements each cycle. Moves to ACCESS on the cycle after counter==0.
  - Request dropped (both low) → FREE next cycle, no memory effect.
  - ramaddr, kind or ramstore differs from the latched values → relatch and restart the count at LAT-1. The count never resumes from a partial value.
- ACCESS lasts exactly one cycle.
  - Read: ramload = mem[latched index], registered on entry to ACCESS.
  - Write: mem[latched index] = latched store, committed at the clock edge that ends ACCESS.
  - Next state is always FREE. A request still asserted is treated as new from FREE, with full latency again.
- Word index = ramaddr[ADDR_W+1:2].
- ramload is 32'h0 outside read ACCESS cycles.
- Memory contents are not cleared by RST.

## Timing
- Reset values: ramstate=FREE, ramload=32'h0, counter=0. Latched request is cleared.
- RST mid-BUSY or mid-ACCESS aborts the access; a pending write is discarded.
- Request first sampled at edge t:
  - ramstate is BUSY for cycles t+1..t+LAT.
  - ramstate is ACCESS at cycle t+LAT+1.
  - Latency is LAT+1 cycles.
- Back-to-back accesses take at least LAT+2 cycles apart (one FREE cycle between them).
- Read-after-write to the same word returns the new value, because the write commits before the next FREE cycle.

## Configuration
- RAM_ERROR_CHECK_EN defined: the following go to ERROR instead of BUSY:
  - ramREN&ramWEN together;
  - ramaddr[1:0]!=0;
  - ramaddr >= DEPTH*4.
- ERROR is held while the offending request stays asserted, then FREE the cycle after it drops. Memory is not touched and ramload=32'h0.
- RAM_ERROR_CHECK_EN undefined: ERROR is never produced.
  - The address wraps modulo DEPTH and the low two bits are ignored.
  - Simultaneous REN/WEN is treated as a write.

## Structure
- ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3) and word_t belong in cpu_types_pkg, shared with the memory controller.
- The local state enum and counter stay in the module.
- One sub-module: ram_array — DEPTH×32 storage with a synchronous write port and an asynchronous read port. The FSM, latching and counter live in ram_responder.

## Test plan
- Reset: assert RST mid-BUSY of a write to 0x40 with data 0xDEADBEEF → ramstate=FREE immediately; a later read of 0x40 returns its old value.
- LAT=2 read: preload mem[0x10>>2]=0x12345678, hold ramREN with ramaddr=0x10 → BUSY, BUSY, ACCESS with ramload=0x12345678, then FREE.
- LAT=2 write then read: write 0xCAFEF00D to 0x200, then read 0x200 → ACCESS on cycles 3 and 7 after the first request; the read returns 0xCAFEF00D.
- Request change: ramaddr 0x20→0x24 on the first BUSY cycle with LAT=3 → ACCESS occurs 4 cycles after the change, with data from 0x24.
- LAT=0: hold ramREN continuously → ACCESS/FREE alternate every cycle.
- With RAM_ERROR_CHECK_EN:
  - ramaddr=0x3 → ERROR until ramREN drops, then FREE.
  - REN and WEN together → ERROR.
  - Without the macro, the same stimulus on 0x3 reads word 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM-port types used by the memory controller and ram_responder
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if: single RAM port between the memory controller (master) and the RAM (slave)
interface ram_responder_if;
    import cpu_types_pkg::*;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
    modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_array.sv
// ram_array: DEPTH x 32 storage, synchronous write port, asynchronous read port, never cleared
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);
    word_t mem [DEPTH];
    // write port commits at the clock edge
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM target with LAT wait states; RAM_ERROR_CHECK_EN enables ERROR on bad requests
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic            CLK,
    input logic            RST,
    ram_responder_if.slave bus
);
    typedef enum logic [1:0] {S_FREE, S_BUSY, S_ACCESS, S_ERROR} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LAT == 0 ? 0 : LAT - 1);
    localparam state_t S_START = (LAT == 0) ? S_ACCESS : S_BUSY;
    state_t     state, next;
    logic [3:0] cnt, cnt_n;
    logic       l_wr, n_wr;
    word_t      l_addr, n_addr, l_store, n_store, rdata;
    logic       req, wr_in, changed, bad;
    assign req     = bus.ramREN | bus.ramWEN;
    assign wr_in   = bus.ramWEN;
    assign changed = (bus.ramaddr != l_addr) || (wr_in != l_wr) || (bus.ramstore != l_store);
`ifdef RAM_ERROR_CHECK_EN
    assign bad = (bus.ramREN & bus.ramWEN) | (bus.ramaddr[1:0] != 2'b00) | (|(bus.ramaddr >> (ADDR_W + 2)));
`else
    assign bad = 1'b0;
`endif
    // next state, counter and request latch
    always_comb begin
        next    = state;
        cnt_n   = cnt;
        n_wr    = l_wr;
        n_addr  = l_addr;
        n_store = l_store;
        case (state)
            S_FREE: begin
                if (req && bad) next = S_ERROR;
                else if (req) begin
                    next    = S_START;
                    cnt_n   = CNT_INIT;
                    n_wr    = wr_in;
                    n_addr  = bus.ramaddr;
                    n_store = bus.ramstore;
                end
            end
            S_BUSY: begin
                if (!req) next = S_FREE;
                else if (changed) begin
                    cnt_n   = CNT_INIT;
                    n_wr    = wr_in;
                    n_addr  = bus.ramaddr;
                    n_store = bus.ramstore;
                end
                else if (cnt == 4'd0) next = S_ACCESS;
                else cnt_n = cnt - 4'd1;
            end
            S_ACCESS: next = S_FREE;
            default:  next = req ? S_ERROR : S_FREE;
        endcase
    end
    // state, latch and read-data registers; read data is captured on entry to a read ACCESS
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_FREE;
            cnt         <= 4'd0;
            l_wr        <= 1'b0;
            l_addr      <= '0;
            l_store     <= '0;
            bus.ramload <= '0;
        end else begin
            state       <= next;
            cnt         <= cnt_n;
            l_wr        <= n_wr;
            l_addr      <= n_addr;
            l_store     <= n_store;
            bus.ramload <= (next == S_ACCESS && !n_wr) ? rdata : '0;
        end
    end
    assign bus.ramstate = (state == S_BUSY)   ? BUSY :
                          (state == S_ACCESS) ? ACCESS :
                          (state == S_ERROR)  ? ERROR : FREE;
    ram_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .CLK   (CLK),
        .we    (state == S_ACCESS && l_wr),
        .waddr (l_addr[ADDR_W+1:2]),
        .wdata (l_store),
        .raddr (n_addr[ADDR_W+1:2]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of ram_responder at LAT=0, 2 and 3 sharing one request stream
module tb_ram_responder;
    import cpu_types_pkg::*;
    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      ren = 1'b0;
    logic      wen = 1'b0;
    word_t     addr = '0;
    word_t     store = '0;
    ramstate_t st [3];
    word_t     ld [3];
    int        passed = 0;
    int        total = 0;
    int        cyc, cyc2, n;
    word_t     q;

    always #5 CLK = ~CLK;

    ram_responder_if bus [3] ();
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].ramREN   = ren;
        assign bus[g].ramWEN   = wen;
        assign bus[g].ramaddr  = addr;
        assign bus[g].ramstore = store;
        assign st[g]           = bus[g].ramstate;
        assign ld[g]           = bus[g].ramload;
        ram_responder #(.LAT(g == 0 ? 0 : g + 1)) dut (
            .CLK (CLK),
            .RST (RST),
            .bus (bus[g])
        );
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic op(input int sel, input logic r, input logic w, input word_t a, input word_t d,
                      output int c, output word_t rd);
        ren = r; wen = w; addr = a; store = d; c = 99; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (st[sel] == ACCESS) begin
                c = i; rd = ld[sel];
                break;
            end
        end
        ren = 1'b0; wen = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (st[1] !== FREE) $display("FAIL reset_state: got %0d want %0d", st[1], FREE); else passed++;
        total++; if (ld[1] !== 32'h0) $display("FAIL reset_load: got %h want %h", ld[1], 32'h0); else passed++;
        RST = 1'b0;
        tick();
        op(1, 1'b0, 1'b1, 32'h40, 32'h11111111, cyc, q);
        total++; if (cyc !== 3) $display("FAIL reset_prewrite_lat: got %0d want %0d", cyc, 3); else passed++;
        wen = 1'b1; addr = 32'h40; store = 32'hDEADBEEF;
        tick(); tick();
        total++; if (st[1] !== BUSY) $display("FAIL reset_busy: got %0d want %0d", st[1], BUSY); else passed++;
        RST = 1'b1;
        #1;
        total++; if (st[1] !== FREE) $display("FAIL reset_async: got %0d want %0d", st[1], FREE); else passed++;
        wen = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        op(1, 1'b1, 1'b0, 32'h40, 32'h0, cyc, q);
        total++; if (q !== 32'h11111111) $display("FAIL reset_abort_data: got %h want %h", q, 32'h11111111); else passed++;
    endtask

    task automatic test_read();
        op(1, 1'b0, 1'b1, 32'h10, 32'h12345678, cyc, q);
        ren = 1'b1; addr = 32'h10;
        tick();
        total++; if (st[1] !== BUSY) $display("FAIL read_busy1: got %0d want %0d", st[1], BUSY); else passed++;
        total++; if (ld[1] !== 32'h0) $display("FAIL read_load_busy: got %h want %h", ld[1], 32'h0); else passed++;
        tick();
        total++; if (st[1] !== BUSY) $display("FAIL read_busy2: got %0d want %0d", st[1], BUSY); else passed++;
        tick();
        total++; if (st[1] !== ACCESS) $display("FAIL read_access: got %0d want %0d", st[1], ACCESS); else passed++;
        total++; if (ld[1] !== 32'h12345678) $display("FAIL read_data: got %h want %h", ld[1], 32'h12345678); else passed++;
        ren = 1'b0;
        tick();
        total++; if (st[1] !== FREE) $display("FAIL read_free: got %0d want %0d", st[1], FREE); else passed++;
        total++; if (ld[1] !== 32'h0) $display("FAIL read_load_free: got %h want %h", ld[1], 32'h0); else passed++;
    endtask

    task automatic test_write_read();
        op(1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, cyc, q);
        op(1, 1'b1, 1'b0, 32'h200, 32'h0, cyc2, q);
        total++; if (cyc !== 3) $display("FAIL wr_access_cycle: got %0d want %0d", cyc, 3); else passed++;
        total++; if (cyc + 1 + cyc2 !== 7) $display("FAIL rd_access_cycle: got %0d want %0d", cyc + 1 + cyc2, 7); else passed++;
        total++; if (q !== 32'hCAFEF00D) $display("FAIL raw_data: got %h want %h", q, 32'hCAFEF00D); else passed++;
    endtask

    task automatic test_change();
        op(2, 1'b0, 1'b1, 32'h20, 32'hAAAA0020, cyc, q);
        op(2, 1'b0, 1'b1, 32'h24, 32'hBBBB0024, cyc, q);
        total++; if (cyc !== 4) $display("FAIL lat3_latency: got %0d want %0d", cyc, 4); else passed++;
        ren = 1'b1; addr = 32'h20;
        tick();
        total++; if (st[2] !== BUSY) $display("FAIL change_busy: got %0d want %0d", st[2], BUSY); else passed++;
        addr = 32'h24; n = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (st[2] == ACCESS) begin
                n = i;
                break;
            end
        end
        total++; if (n !== 4) $display("FAIL change_delay: got %0d want %0d", n, 4); else passed++;
        total++; if (ld[2] !== 32'hBBBB0024) $display("FAIL change_data: got %h want %h", ld[2], 32'hBBBB0024); else passed++;
        ren = 1'b0;
        tick(); tick();
    endtask

    task automatic test_lat0();
        ren = 1'b1; addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (st[0] !== ((i % 2 == 0) ? ACCESS : FREE))
                $display("FAIL lat0_state%0d: got %0d want %0d", i, st[0], (i % 2 == 0) ? ACCESS : FREE);
            else passed++;
            if (i % 2 == 0) begin
                total++; if (ld[0] !== 32'h12345678) $display("FAIL lat0_data%0d: got %h want %h", i, ld[0], 32'h12345678); else passed++;
            end
        end
        ren = 1'b0;
        tick(); tick();
    endtask

`ifdef RAM_ERROR_CHECK_EN
    task automatic test_error();
        ren = 1'b1; addr = 32'h3;
        tick();
        total++; if (st[1] !== ERROR) $display("FAIL err_misalign: got %0d want %0d", st[1], ERROR); else passed++;
        tick();
        total++; if (st[1] !== ERROR) $display("FAIL err_hold: got %0d want %0d", st[1], ERROR); else passed++;
        total++; if (ld[1] !== 32'h0) $display("FAIL err_load: got %h want %h", ld[1], 32'h0); else passed++;
        ren = 1'b0;
        tick();
        total++; if (st[1] !== FREE) $display("FAIL err_release: got %0d want %0d", st[1], FREE); else passed++;
        ren = 1'b1; wen = 1'b1; addr = 32'h40;
        tick();
        total++; if (st[1] !== ERROR) $display("FAIL err_both: got %0d want %0d", st[1], ERROR); else passed++;
        ren = 1'b0; wen = 1'b0;
        tick();
        ren = 1'b1; addr = 32'h10010;
        tick();
        total++; if (st[1] !== ERROR) $display("FAIL err_range: got %0d want %0d", st[1], ERROR); else passed++;
        ren = 1'b0;
        tick(); tick();
    endtask
`else
    task automatic test_no_check();
        op(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, cyc, q);
        op(1, 1'b1, 1'b0, 32'h3, 32'h0, cyc, q);
        total++; if (cyc !== 3) $display("FAIL misalign_lat: got %0d want %0d", cyc, 3); else passed++;
        total++; if (q !== 32'h0BADF00D) $display("FAIL misalign_data: got %h want %h", q, 32'h0BADF00D); else passed++;
        op(1, 1'b1, 1'b0, 32'h10010, 32'h0, cyc, q);
        total++; if (q !== 32'h12345678) $display("FAIL wrap_data: got %h want %h", q, 32'h12345678); else passed++;
        op(1, 1'b1, 1'b1, 32'h30, 32'h55AA55AA, cyc, q);
        op(1, 1'b1, 1'b0, 32'h30, 32'h0, cyc, q);
        total++; if (q !== 32'h55AA55AA) $display("FAIL both_is_write: got %h want %h", q, 32'h55AA55AA); else passed++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_change();
        test_lat0();
`ifdef RAM_ERROR_CHECK_EN
        test_error();
`else
        test_no_check();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
